hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, sets the number of consecutive memory-busy cycles that escalates to HALT; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Rs1D, Rs2D  in  5 each  source registers of the Decode instruction.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the Execute instruction.
REQ-006 RdM, RdW  in  5 each  destination registers in Memory and Writeback.
REQ-007 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-008 ResultSrcE  in  2  Execute result select; 2'b01 marks a load.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-010 MemReqM, MemReadyM  in  1 each  data-memory request and ready handshake.
REQ-011 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-013 FlushD, FlushE, FlushW  out  1 each  clear the corresponding pipeline register to a bubble.
REQ-014 halted  out  1  sticky memory-timeout indication.
REQ-015 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; else 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; else 00; ForwardBE likewise using Rs2E.
REQ-017 lwStall SHALL be 1 when ResultSrcE==01, RdE!=0 and RdE equals Rs1D or Rs2D.
REQ-018 mem_busy SHALL be MemReqM & ~MemReadyM; freeze SHALL be mem_busy or state==HALT.
REQ-019 FSM states: RUN, WAIT, HALT; an 8-bit wait_cnt counts consecutive mem_busy cycles.
REQ-020 RUN->WAIT on mem_busy; WAIT->RUN on ~mem_busy; RUN or WAIT ->HALT when mem_busy and wait_cnt==MEM_TIMEOUT-1; HALT is left only by rst.
REQ-021 wait_cnt SHALL increment on each mem_busy cycle and clear to 0 on any cycle with ~mem_busy.
REQ-022 When freeze=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0, regardless of lwStall or PCSrcE.
REQ-023 When freeze=0: StallF=StallD=lwStall & ~PCSrcE, StallE=StallM=0, FlushD=PCSrcE, FlushE=PCSrcE|lwStall, FlushW=0.
REQ-024 A branch that arrives during freeze SHALL be held in Execute and acted on in the first cycle after freeze deasserts; PCSrcE has priority over lwStall.
REQ-025 All stall and flush outputs SHALL be combinational, taking effect in the same cycle as their cause; forwarding stays active during freeze.
REQ-026 stall_cnt SHALL increment by 1 on each clock where any Stall* output is 1, saturating at 16'hFFFF.
REQ-027 flush_cnt SHALL increment by 1 on each clock where FlushD or FlushE is 1 while freeze=0, saturating at 16'hFFFF.
REQ-028 halted SHALL equal (state==HALT).

Reset
REQ-029 While rst=1: state=RUN, wait_cnt=0, counters=0, halted=0, all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
REQ-030 rst asserted mid-WAIT or in HALT SHALL return the block to RUN on the next edge, with counters cleared.

Verification
REQ-031 Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with Rs1E=0 -> ForwardAE=00.
REQ-032 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, stall_cnt +1, flush_cnt +1.
REQ-033 Branch: PCSrcE=1 with a simultaneous lwStall condition -> FlushD=FlushE=1, StallF=0.
REQ-034 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> all Stall*=1 and FlushW=1 for exactly 3 cycles, then RUN, stall_cnt=3.
REQ-035 Timeout: MEM_TIMEOUT=4, MemReadyM held 0 -> halted=1 after the 4th busy edge and stays 1 after MemReadyM=1; rst -> halted=0.
REQ-036 Saturation: force 65536+ stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use
// stalls, branch flushes, memory-wait freezing with a timeout-to-HALT FSM,
// and saturating stall/flush event counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    // Busy count at which one more busy cycle escalates to HALT.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       mem_busy;
    logic       freeze;
    logic       lw_stall;
    logic       any_stall;
    logic       flush_event;

    assign mem_busy    = MemReqM & ~MemReadyM;
    assign freeze      = mem_busy | (state == ST_HALT);
    assign lw_stall    = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));
    assign any_stall   = StallF | StallD | StallE | StallM;
    assign flush_event = (FlushD | FlushE) & ~freeze;
    // Reset masks the sticky flag so it drops as soon as reset is applied.
    assign halted      = (state == ST_HALT) && !rst;

    // Forwarding select: the younger Memory-stage result wins over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    // Stall/flush generation; a freeze holds every stage so a pending branch stays in Execute.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall & ~PCSrcE;
            StallD = lw_stall & ~PCSrcE;
            FlushD = PCSrcE;
            FlushE = PCSrcE | lw_stall;
        end
    end

    // Next-state logic for the memory-wait FSM; HALT is only left through reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mem_busy)
                    state_next = (wait_cnt == WAIT_LIMIT) ? ST_HALT : ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_busy)
                    state_next = ST_RUN;
                else if (wait_cnt == WAIT_LIMIT)
                    state_next = ST_HALT;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RUN;
        endcase
    end

    // State register and consecutive-busy counter (saturates so a long HALT cannot wrap it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (!mem_busy)
                wait_cnt <= 8'd0;
            else if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Saturating event counters; flushes only count when the pipeline is moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (any_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_event && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule
